maquina_estados_param: RTL and testbench
========================================

Name: maquina_estados_param

Overview:
- Parametrised successor of the QoS interface control FSM for the PCIe TC/VC path.
- Supports N FIFOs, and configurable virtual-channel and destination counts and threshold widths.
- Latches thresholds into a committed register bank when initialisation completes.
- Debounces the ACTIVE→IDLE transition, keeps a sticky per-FIFO error record, and provides an explicit error-recovery handshake.
- Sits between the register/config interface and the FIFO/arbiter datapath; drives the thresholds and status flags consumed there.

Parameters:
NUM_FIFO, 5, number of monitored FIFOs
NUM_VC, 2, number of virtual-channel thresholds
VC_W, 16, width of each VC threshold
NUM_D, 2, number of destination thresholds
D_W, 4, width of each destination threshold
MF_W, 4, width of main-FIFO threshold
IDLE_HOLD, 3, consecutive all-empty cycles required before ACTIVE→IDLE (≥1)

Ports:
clk  in  1  clock, all state on rising edge
reset  in  1  asynchronous active-low reset
init  in  1  initialisation request; level-sensitive
umbral_mf_in  in  MF_W  main-FIFO threshold to load
umbral_vc_in  in  NUM_VC*VC_W  VC thresholds; VC0 in MSBs
umbral_d_in  in  NUM_D*D_W  destination thresholds; D0 in MSBs
fifo_empty  in  NUM_FIFO  bit i=1 means FIFO i empty
fifo_error  in  NUM_FIFO  bit i=1 means FIFO i overflow/underflow
err_clear  in  1  request exit from ERROR
state_out  out  3  current state encoding
idle_out  out  1  high in IDLE
active_out  out  1  high in ACTIVE
error_out  out  1  high in ERROR
umbral_mf  out  MF_W  committed main-FIFO threshold
umbral_vc  out  NUM_VC*VC_W  committed VC thresholds
umbral_d  out  NUM_D*D_W  committed destination thresholds
error_full  out  NUM_FIFO  sticky per-FIFO error record

Behaviour:
- State encoding: RESET=0, INIT=1, IDLE=2, ACTIVE=3, ERROR=4. The state register, counter, committed thresholds and error_full are all registered.
- Status flags are Moore outputs decoded from the state register. A flag asserts in the first cycle the FSM is in that state.
- While reset=0 (asynchronous assert): state=RESET; all outputs 0; hold counter 0. Deassertion takes effect at the next clk edge.
- All-empty condition: &fifo_empty. Any-error condition: |fifo_error.
- Transition priority in every non-RESET state: any-error > init > emptiness.
- RESET: next edge goes unconditionally to INIT.
- INIT:
  - any-error → ERROR.
  - init=1 → stay in INIT.
  - init=0: commit umbral_*_in into umbral_* at this edge, then go to IDLE if all-empty, else ACTIVE.
  - Committed values are visible the cycle after init is sampled low.
  - Thresholds are never committed outside INIT; umbral_* hold their value otherwise.
- IDLE:
  - any-error → ERROR.
  - init=1 → INIT.
  - Not all-empty → ACTIVE.
  - Otherwise stay.
- ACTIVE:
  - any-error → ERROR.
  - init=1 → INIT.
  - Hold counter increments each cycle all-empty is true and clears on any non-empty cycle.
  - When the counter reaches IDLE_HOLD-1 and all-empty is still true → IDLE, with the counter cleared.
  - The counter saturates and never wraps; its width is clog2(IDLE_HOLD+1).
  - With IDLE_HOLD=1, ACTIVE→IDLE happens on the first all-empty cycle.
- ERROR:
  - error_full <= error_full | fifo_error every cycle. The first erroring bits are captured on the edge that enters ERROR.
  - err_clear=1 and fifo_error==0 → INIT; error_full is cleared on that edge.
  - err_clear=1 while errors persist: stay in ERROR, record retained.
  - init has no effect in ERROR.
- error_full is 0 in every state except ERROR.
- Reset mid-operation:
  - Immediately zeroes all outputs, including the committed thresholds.
  - A full INIT sequence is required afterwards.

Test Plan:
- Reset release with init=1, umbral_mf_in=4'hA, umbral_vc_in=32'h1234_5678, umbral_d_in=8'h3C; drop init with fifo_empty=5'h1F → states RESET→INIT→IDLE; idle_out=1; umbral_mf=A, umbral_vc=12345678, umbral_d=3C the cycle after init falls.
- Change umbral_*_in while in IDLE/ACTIVE → umbral_* unchanged. Reassert init → INIT, and the new values commit on exit.
- In IDLE drive fifo_empty=5'h1E → ACTIVE next cycle. Restore 5'h1F for 2 cycles, then 5'h1E, then 5'h1F for 3 cycles → IDLE only after the third consecutive empty cycle.
- In ACTIVE pulse fifo_error=5'h04, then 5'h10 → ERROR, error_out=1, error_full=5'h14. Hold err_clear=1 with fifo_error=5'h10 → stay in ERROR. Set fifo_error=0 → INIT, error_full=0.
- fifo_error=5'h01 and init=1 in the same cycle from IDLE → ERROR (error has priority over init).
- Assert reset=0 mid-ACTIVE, between clock edges → all outputs 0 immediately with no clock edge. After release, path is RESET→INIT and umbral_* stay 0 until the next commit.

Source files
------------

// File: rtl/maquina_estados_param.sv
// QoS interface control FSM for the PCIe TC/VC path: commits thresholds on INIT exit, debounces ACTIVE->IDLE, tracks sticky FIFO errors.
// All outputs are registered or decoded from the state register (one-cycle response); no backpressure, every input is sampled each cycle.
module maquina_estados_param #(
  parameter int NUM_FIFO  = 5,
  parameter int NUM_VC    = 2,
  parameter int VC_W      = 16,
  parameter int NUM_D     = 2,
  parameter int D_W       = 4,
  parameter int MF_W      = 4,
  parameter int IDLE_HOLD = 3
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    init,
  input  logic [MF_W-1:0]         umbral_mf_in,
  input  logic [NUM_VC*VC_W-1:0]  umbral_vc_in,
  input  logic [NUM_D*D_W-1:0]    umbral_d_in,
  input  logic [NUM_FIFO-1:0]     fifo_empty,
  input  logic [NUM_FIFO-1:0]     fifo_error,
  input  logic                    err_clear,
  output logic [2:0]              state_out,
  output logic                    idle_out,
  output logic                    active_out,
  output logic                    error_out,
  output logic [MF_W-1:0]         umbral_mf,
  output logic [NUM_VC*VC_W-1:0]  umbral_vc,
  output logic [NUM_D*D_W-1:0]    umbral_d,
  output logic [NUM_FIFO-1:0]     error_full
);

  localparam logic [2:0] S_RESET  = 3'd0;
  localparam logic [2:0] S_INIT   = 3'd1;
  localparam logic [2:0] S_IDLE   = 3'd2;
  localparam logic [2:0] S_ACTIVE = 3'd3;
  localparam logic [2:0] S_ERROR  = 3'd4;

  localparam int CW = $clog2(IDLE_HOLD + 1);
  localparam logic [CW-1:0] HOLD_LAST = CW'(IDLE_HOLD - 1);
  localparam logic [CW-1:0] CNT_MAX   = CW'(IDLE_HOLD);
  localparam logic [CW-1:0] CNT_ONE   = CW'(1);

  logic [2:0]               state_q, state_d;
  logic [CW-1:0]            cnt_q, cnt_d;
  logic [NUM_FIFO-1:0]      err_q, err_d;
  logic [MF_W-1:0]          mf_q, mf_d;
  logic [NUM_VC*VC_W-1:0]   vc_q, vc_d;
  logic [NUM_D*D_W-1:0]     d_q, d_d;

  logic all_empty;
  logic any_err;

  assign all_empty = &fifo_empty;
  assign any_err   = |fifo_error;

  always_comb begin
    state_d = state_q;
    cnt_d   = '0;
    err_d   = '0;
    mf_d    = mf_q;
    vc_d    = vc_q;
    d_d     = d_q;
    case (state_q)
      S_RESET: state_d = S_INIT;
      S_INIT: begin
        if (any_err) begin
          state_d = S_ERROR;
          err_d   = fifo_error;
        end else if (!init) begin
          mf_d    = umbral_mf_in;
          vc_d    = umbral_vc_in;
          d_d     = umbral_d_in;
          state_d = all_empty ? S_IDLE : S_ACTIVE;
        end
      end
      S_IDLE: begin
        if (any_err) begin
          state_d = S_ERROR;
          err_d   = fifo_error;
        end else if (init) begin
          state_d = S_INIT;
        end else if (!all_empty) begin
          state_d = S_ACTIVE;
        end
      end
      S_ACTIVE: begin
        if (any_err) begin
          state_d = S_ERROR;
          err_d   = fifo_error;
        end else if (init) begin
          state_d = S_INIT;
        end else if (all_empty) begin
          // Debounce: leave only after IDLE_HOLD consecutive all-empty cycles.
          if (cnt_q == HOLD_LAST) begin
            state_d = S_IDLE;
          end else if (cnt_q != CNT_MAX) begin
            cnt_d = cnt_q + CNT_ONE;
          end else begin
            cnt_d = cnt_q;
          end
        end
      end
      S_ERROR: begin
        if (err_clear && !any_err) begin
          state_d = S_INIT;
        end else begin
          err_d = err_q | fifo_error;
        end
      end
      default: state_d = S_RESET;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_RESET;
      cnt_q   <= '0;
      err_q   <= '0;
      mf_q    <= '0;
      vc_q    <= '0;
      d_q     <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      mf_q    <= mf_d;
      vc_q    <= vc_d;
      d_q     <= d_d;
    end
  end

  assign state_out  = state_q;
  assign idle_out   = (state_q == S_IDLE);
  assign active_out = (state_q == S_ACTIVE);
  assign error_out  = (state_q == S_ERROR);
  assign umbral_mf  = mf_q;
  assign umbral_vc  = vc_q;
  assign umbral_d   = d_q;
  assign error_full = err_q;

endmodule

// File: tb/tb_maquina_estados_param.sv
// Scoreboard bench for maquina_estados_param: each driven cycle pushes its expected outputs, checked after the next edge.
module tb_maquina_estados_param;

  logic        clk;
  logic        reset;
  logic        init;
  logic [3:0]  umbral_mf_in;
  logic [31:0] umbral_vc_in;
  logic [7:0]  umbral_d_in;
  logic [4:0]  fifo_empty;
  logic [4:0]  fifo_error;
  logic        err_clear;
  logic [2:0]  state_out;
  logic        idle_out;
  logic        active_out;
  logic        error_out;
  logic [3:0]  umbral_mf;
  logic [31:0] umbral_vc;
  logic [7:0]  umbral_d;
  logic [4:0]  error_full;

  localparam logic [2:0] S_RESET  = 3'd0;
  localparam logic [2:0] S_INIT   = 3'd1;
  localparam logic [2:0] S_IDLE   = 3'd2;
  localparam logic [2:0] S_ACTIVE = 3'd3;
  localparam logic [2:0] S_ERROR  = 3'd4;

  typedef struct packed {
    logic [2:0]  st;
    logic [3:0]  mf;
    logic [31:0] vc;
    logic [7:0]  d;
    logic [4:0]  ef;
  } exp_t;

  exp_t sb[$];
  int total = 0;
  int bad   = 0;

  logic [3:0]  exp_mf;
  logic [31:0] exp_vc;
  logic [7:0]  exp_d;

  maquina_estados_param dut (
    .clk          (clk),
    .reset        (reset),
    .init         (init),
    .umbral_mf_in (umbral_mf_in),
    .umbral_vc_in (umbral_vc_in),
    .umbral_d_in  (umbral_d_in),
    .fifo_empty   (fifo_empty),
    .fifo_error   (fifo_error),
    .err_clear    (err_clear),
    .state_out    (state_out),
    .idle_out     (idle_out),
    .active_out   (active_out),
    .error_out    (error_out),
    .umbral_mf    (umbral_mf),
    .umbral_vc    (umbral_vc),
    .umbral_d     (umbral_d),
    .error_full   (error_full)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic chk_all(input string tag, input exp_t e);
    chk({tag, ".state"},  state_out,  e.st);
    chk({tag, ".idle"},   idle_out,   e.st == S_IDLE);
    chk({tag, ".active"}, active_out, e.st == S_ACTIVE);
    chk({tag, ".error"},  error_out,  e.st == S_ERROR);
    chk({tag, ".mf"},     umbral_mf,  e.mf);
    chk({tag, ".vc"},     umbral_vc,  e.vc);
    chk({tag, ".d"},      umbral_d,   e.d);
    chk({tag, ".ef"},     error_full, e.ef);
  endtask

  // Inputs are already set; push what the DUT must show after the next edge.
  task automatic cyc(input string tag, input logic [2:0] st, input logic [4:0] ef);
    exp_t e;
    sb.push_back('{st: st, mf: exp_mf, vc: exp_vc, d: exp_d, ef: ef});
    @(posedge clk);
    #1;
    e = sb.pop_front();
    chk_all(tag, e);
  endtask

  initial begin
    exp_t z;
    reset        = 1'b0;
    init         = 1'b1;
    umbral_mf_in = 4'hA;
    umbral_vc_in = 32'h1234_5678;
    umbral_d_in  = 8'h3C;
    fifo_empty   = 5'h1F;
    fifo_error   = 5'h00;
    err_clear    = 1'b0;
    exp_mf = '0; exp_vc = '0; exp_d = '0;
    z = '0;

    #3;
    chk_all("rst", z);
    @(negedge clk);
    chk_all("rst_hold", z);
    reset = 1'b1;

    cyc("rst_to_init", S_INIT, 5'h00);
    cyc("init_hold", S_INIT, 5'h00);
    init = 1'b0;
    exp_mf = 4'hA; exp_vc = 32'h1234_5678; exp_d = 8'h3C;
    cyc("commit_idle", S_IDLE, 5'h00);

    umbral_mf_in = 4'h5; umbral_vc_in = 32'h9ABC_DEF0; umbral_d_in = 8'h81;
    cyc("idle_no_commit", S_IDLE, 5'h00);

    fifo_empty = 5'h1E;
    cyc("to_active", S_ACTIVE, 5'h00);
    fifo_empty = 5'h1F;
    cyc("empty1", S_ACTIVE, 5'h00);
    cyc("empty2", S_ACTIVE, 5'h00);
    fifo_empty = 5'h1E;
    cyc("busy_clr", S_ACTIVE, 5'h00);
    fifo_empty = 5'h1F;
    cyc("deb1", S_ACTIVE, 5'h00);
    cyc("deb2", S_ACTIVE, 5'h00);
    cyc("deb3_idle", S_IDLE, 5'h00);

    init = 1'b1;
    cyc("reinit", S_INIT, 5'h00);
    cyc("reinit_hold", S_INIT, 5'h00);
    init = 1'b0;
    fifo_empty = 5'h1E;
    exp_mf = 4'h5; exp_vc = 32'h9ABC_DEF0; exp_d = 8'h81;
    cyc("recommit_active", S_ACTIVE, 5'h00);

    fifo_error = 5'h04;
    cyc("err_enter", S_ERROR, 5'h04);
    fifo_error = 5'h10;
    cyc("err_accum", S_ERROR, 5'h14);
    init = 1'b1;
    cyc("err_init_ign", S_ERROR, 5'h14);
    init = 1'b0;
    err_clear = 1'b1;
    cyc("err_clr_persist", S_ERROR, 5'h14);
    fifo_error = 5'h00;
    cyc("err_clr_ok", S_INIT, 5'h00);
    err_clear = 1'b0;
    fifo_empty = 5'h1F;
    cyc("post_err_idle", S_IDLE, 5'h00);

    fifo_error = 5'h01;
    init = 1'b1;
    cyc("err_over_init", S_ERROR, 5'h01);
    fifo_error = 5'h00;
    init = 1'b0;
    err_clear = 1'b1;
    cyc("err_exit2", S_INIT, 5'h00);
    err_clear = 1'b0;
    fifo_empty = 5'h1E;
    cyc("active_again", S_ACTIVE, 5'h00);

    #2;
    reset = 1'b0;
    #1;
    chk_all("async_rst", z);
    exp_mf = '0; exp_vc = '0; exp_d = '0;
    @(negedge clk);
    reset = 1'b1;
    init = 1'b1;
    umbral_mf_in = 4'h7; umbral_vc_in = 32'hCAFE_0001; umbral_d_in = 8'hE2;
    cyc("rst2_init", S_INIT, 5'h00);
    cyc("rst2_hold", S_INIT, 5'h00);
    init = 1'b0;
    exp_mf = 4'h7; exp_vc = 32'hCAFE_0001; exp_d = 8'hE2;
    cyc("rst2_commit", S_ACTIVE, 5'h00);

    if (sb.size() != 0) begin
      bad++;
      $display("FAIL sb_drain: got %0d entries expected 0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
